// File: rtl/cap_pkg.sv
// Shared definitions for the camera capture controller: state encoding,
// default geometry and the frame counter width.
package cap_pkg;

    localparam int AW_DEF      = 15;
    localparam int NPIX_DEF    = 19200;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/edge_det.sv
// One-bit edge detector: registers the input once and flags rising and
// falling transitions against the registered copy.
module edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // Previous-cycle copy of the input, cleared by reset.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = ~d_q & d;
    assign fall = d_q & ~d;

endmodule

// File: rtl/cap_ctrl.sv
// Frame capture controller: arms on start, captures one camera frame between
// vsync fall and vsync rise into a shared single-port buffer, and hands the
// buffer port to a consumer whenever no capture is running.
module cap_ctrl
    import cap_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int NPIX = NPIX_DEF
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   vsync,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic                   cam_wr,
    input  logic [AW-1:0]          cam_addr,
    input  logic [7:0]             cam_data,
    input  logic                   rd_req,
    input  logic [AW-1:0]          rd_addr,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata,
    output logic                   cap_en,
    output logic                   rd_grant,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err_ovf,
    output logic                   err_short,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [AW:0] NPIX_V = (AW+1)'(NPIX);

    cap_state_t  state;
    cap_state_t  state_nxt;
    logic        vs_rise;
    logic        vs_fall;
    logic        clr_run;
    logic        clr_err;
    logic        frame_end;
    logic [AW:0] pix_cnt;
    logic [AW:0] pix_after;
    logic        addr_ok;
    logic        wr_hit;
    logic        wr_ovf;
    logic        port_free;
    logic        rd_hit;
    logic        rd_vld_p1;
    logic        rd_vld_p2;

    // Pixel counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    edge_det u_vsync_edge (
        .pclk (pclk),
        .rst  (rst),
        .d    (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    // The camera owns the buffer port only while capturing; the consumer
    // owns it in IDLE and DONE, so the two sources never collide.
    assign port_free = (state == ST_IDLE) || (state == ST_DONE);
    assign addr_ok   = ({1'b0, cam_addr} < NPIX_V);
    assign wr_hit    = (state == ST_CAPTURE) && cam_wr && addr_ok;
    assign wr_ovf    = (state == ST_CAPTURE) && cam_wr && !addr_ok;
    assign rd_hit    = port_free && rd_req;
    assign pix_after = wr_hit ? sat_inc(pix_cnt) : pix_cnt;

    // Next-state decode; stop always wins and returns to IDLE.
    always_comb begin
        state_nxt = state;
        clr_run   = 1'b0;
        clr_err   = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!stop && start) begin
                    state_nxt = ST_ARM;
                    clr_run   = 1'b1;
                    clr_err   = 1'b1;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (vs_fall) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (vs_rise) begin
                    state_nxt = ST_DONE;
                    frame_end = 1'b1;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt = ST_ARM;
                    clr_run   = 1'b1;
                    clr_err   = 1'b1;
                end else if (mode) begin
                    state_nxt = ST_ARM;
                    clr_run   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame bookkeeping: pixel count, frame count, done pulse, sticky errors.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            pix_cnt   <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
            err_short <= 1'b0;
        end else begin
            done    <= frame_end;
            pix_cnt <= clr_run ? '0 : pix_after;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (clr_err) begin
                err_ovf   <= 1'b0;
                err_short <= 1'b0;
            end else begin
                if (wr_ovf) begin
                    err_ovf <= 1'b1;
                end
                if (frame_end && (pix_after != NPIX_V)) begin
                    err_short <= 1'b1;
                end
            end
        end
    end

    // Stage p1: registered buffer port, camera write or consumer read address.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            mem_we    <= wr_hit;
            rd_vld_p1 <= rd_hit;
            if (wr_hit) begin
                mem_addr  <= cam_addr;
                mem_wdata <= cam_data;
            end else if (rd_hit) begin
                mem_addr <= rd_addr;
            end
        end
    end

    // Stage p2: buffer data returns; flag it valid for the consumer.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            rd_vld_p2 <= 1'b0;
        end else begin
            rd_vld_p2 <= rd_vld_p1;
        end
    end

    assign rd_valid = rd_vld_p2;
    assign rd_data  = rd_vld_p2 ? mem_rdata : 8'h00;
    assign busy     = rst && ((state == ST_ARM) || (state == ST_CAPTURE));
    assign cap_en   = busy;
    assign rd_grant = rst && port_free;

endmodule

// File: doc/cap_ctrl.md
CAP_CTRL -- requirements
Module: cap_ctrl

Interface
REQ-001 Parameter AW, default 15, buffer address width.
REQ-002 Parameter NPIX, default 19200, pixels per frame (160x120).
REQ-003 pclk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 vsync  in  1  camera frame sync; high = blanking.
REQ-006 start  in  1  one-cycle capture request.
REQ-007 stop  in  1  one-cycle abort request.
REQ-008 mode  in  1  0 = single frame, 1 = continuous.
REQ-009 cam_wr, cam_addr[AW-1:0], cam_data[7:0]  in  pixel write from camera reader.
REQ-010 rd_req, rd_addr[AW-1:0]  in  buffer read request from consumer.
REQ-011 mem_we, mem_addr[AW-1:0], mem_wdata[7:0]  out  registered buffer port.
REQ-012 mem_rdata[7:0]  in  buffer read data, valid 1 cycle after mem_addr.
REQ-013 cap_en  out  1  enables camera reader; high only in ARM and CAPTURE.
REQ-014 rd_grant, rd_valid  out  1; rd_data[7:0] out 8.
REQ-015 busy, done, err_ovf, err_short  out  1; frame_cnt[7:0]  out  8.

Function
REQ-016 FSM states: IDLE, ARM, CAPTURE, DONE.
REQ-017 Edges: vsync_fall = vsync_q & ~vsync; vsync_rise = ~vsync_q & vsync; vsync_q a 1-cycle register.
REQ-018 IDLE: start -> ARM; clears pix_cnt, err_ovf, err_short.
REQ-019 ARM: vsync_fall -> CAPTURE; all cam_wr ignored.
REQ-020 CAPTURE: each cam_wr with cam_addr < NPIX -> mem_we=1, mem_addr=cam_addr, mem_wdata=cam_data next cycle; pix_cnt += 1.
REQ-021 CAPTURE: cam_wr with cam_addr >= NPIX -> no write; err_ovf set, sticky until next start.
REQ-022 CAPTURE: vsync_rise -> DONE; done=1 for exactly one cycle; frame_cnt += 1, wraps 255->0; err_short set if pix_cnt != NPIX.
REQ-023 A cam_wr in the same cycle as vsync_rise is still written and counted.
REQ-024 DONE: mode=1 -> ARM next cycle, pix_cnt cleared; mode=0 -> hold DONE until start (-> ARM, errors cleared) or stop (-> IDLE).
REQ-025 stop in any state -> IDLE next cycle; mid-CAPTURE abort gives no done and leaves frame_cnt unchanged; stop wins over simultaneous start.
REQ-026 start in ARM or CAPTURE is ignored.
REQ-027 rd_grant = 1 only in IDLE and DONE; rd_req otherwise ignored, never queued.
REQ-028 Granted rd_req -> mem_addr=rd_addr, mem_we=0 next cycle; rd_valid=1 and rd_data=mem_rdata one cycle after that (2-cycle latency); back-to-back reads at one per cycle.
REQ-029 The camera owns the port in CAPTURE, so the port is never driven by both sources in one cycle.
REQ-030 busy = 1 in ARM and CAPTURE.
REQ-031 pix_cnt width AW+1; saturates at all-ones and does not wrap.

Reset
REQ-032 rst=0 at a pclk edge -> state IDLE; counters and vsync_q cleared.
REQ-033 All outputs 0 during reset, including mem_we, cap_en, done, errors and frame_cnt.
REQ-034 Reset mid-CAPTURE truncates the write in flight: mem_we=0 on the following cycle.

Structure
REQ-035 Shared package cap_pkg holds the state encoding (2-bit), the AW/NPIX defaults and the FRAME_CNT_W=8 constant.
REQ-036 One sub-module, edge_det (1-bit registered rise/fall detector), instantiated for vsync.

Verification
REQ-037 Start, mode=0, vsync low for 19200 cam_wr then high -> 19200 mem_we pulses, one done pulse, frame_cnt=1, errors=0.
REQ-038 Same frame with 19199 writes -> done pulse and err_short=1; one write at cam_addr 19200 -> err_ovf=1 and no mem_we for it.
REQ-039 mode=1 over three frames -> three done pulses, frame_cnt=3, ARM re-entered after each DONE.
REQ-040 stop at write 5000 of CAPTURE -> IDLE next cycle, no done, frame_cnt unchanged, cap_en=0.
REQ-041 In DONE, rd_req with addr 0..3 on consecutive cycles -> rd_valid high 4 cycles starting 2 cycles later, data matching the written pixels; rd_req in CAPTURE -> rd_grant=0, no rd_valid.
REQ-042 rst=0 asserted mid-CAPTURE -> all outputs 0 next cycle; start and stop in the same cycle from IDLE -> stays IDLE.
